// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 receive path.
// All cycle constants assume a 100 MHz system clock.
package ws2812_pkg;

    localparam int BITS_PER_PIXEL = 24;

    localparam int T0H  = 40;
    localparam int T1H  = 80;
    localparam int TBIT = 125;
    localparam int GAP  = 5000;

    typedef logic [BITS_PER_PIXEL-1:0] pixel_t;

    typedef enum logic [2:0] {
        ST_SYNC_WAIT = 3'd0,
        ST_IDLE      = 3'd1,
        ST_HIGH      = 3'd2,
        ST_LOW       = 3'd3,
        ST_ERR_SKIP  = 3'd4
    } rx_state_e;

endpackage

// File: rtl/ws2812_pulse_meter.sv
// Synchronises the raw WS2812 line, produces registered rise/fall strobes and
// measures high/low durations with saturating counters.
module ws2812_pulse_meter #(
    parameter int MAX_HIGH_CYC = 110,
    parameter int GAP_CYC      = 5000,
    parameter int HW           = $clog2(MAX_HIGH_CYC + 2),
    parameter int LW           = $clog2(GAP_CYC + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_din,
    output logic          o_rise,
    output logic          o_fall,
    output logic [HW-1:0] o_high_cnt,
    output logic          o_gap_hit
);

    localparam logic [HW-1:0] HIGH_SAT = HW'(MAX_HIGH_CYC + 1);
    localparam logic [LW-1:0] LOW_SAT  = LW'(GAP_CYC);

    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic [HW-1:0] r_high_cnt;
    logic [LW-1:0] r_low_cnt;
    logic          w_rise;
    logic          w_fall;

    assign w_rise = r_sync[1] & ~r_level;
    assign w_fall = ~r_sync[1] & r_level;

    // Synchroniser, edge register and saturating pulse-width counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync     <= 2'b00;
            r_level    <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_high_cnt <= '0;
            r_low_cnt  <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_din};
            r_level <= r_sync[1];
            r_rise  <= w_rise;
            r_fall  <= w_fall;
            if (w_rise) begin
                r_high_cnt <= HW'(1);
            end else if (r_sync[1] && (r_high_cnt != HIGH_SAT)) begin
                r_high_cnt <= r_high_cnt + HW'(1);
            end
            // Reset time counts as line-low so the initial gap can be seen
            if (w_rise) begin
                r_low_cnt <= '0;
            end else if (w_fall) begin
                r_low_cnt <= LW'(1);
            end else if (!r_sync[1] && (r_low_cnt != LOW_SAT)) begin
                r_low_cnt <= r_low_cnt + LW'(1);
            end
        end
    end

    assign o_rise     = r_rise;
    assign o_fall     = r_fall;
    assign o_high_cnt = r_high_cnt;
    assign o_gap_hit  = (r_low_cnt == LOW_SAT);

endmodule

// File: rtl/ws2812_rx_decoder.sv
// WS2812 stream decoder: rebuilds GRB pixel words with their strip index and flags the latch gap.
// Define WS2812_RX_STATS_EN to enable the frame_count statistics counter.
module ws2812_rx_decoder #(
    parameter int CLK_HZ         = 100_000_000,
    parameter int BITS_PER_PIXEL = ws2812_pkg::BITS_PER_PIXEL,
    parameter int PX_NUM         = 52,
    parameter int PX_COUNT_WIDTH = 6,
    parameter int MIN_HIGH_CYC   = 15,
    parameter int BIT_THRESH_CYC = 60,
    parameter int MAX_HIGH_CYC   = 110,
    parameter int GAP_CYC        = 5000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      din,
    output logic [BITS_PER_PIXEL-1:0] pixel_data,
    output logic [PX_COUNT_WIDTH-1:0] pixel_idx,
    output logic                      pixel_valid,
    output logic                      frame_done,
    output logic                      bit_err,
    output logic                      overflow,
    output logic [15:0]               frame_count
);
    import ws2812_pkg::*;

    localparam int HW = $clog2(MAX_HIGH_CYC + 2);
    localparam int BW = $clog2(BITS_PER_PIXEL + 1);
    localparam logic [HW-1:0] MIN_H    = HW'(MIN_HIGH_CYC);
    localparam logic [HW-1:0] THR_H    = HW'(BIT_THRESH_CYC);
    localparam logic [HW-1:0] MAX_H    = HW'(MAX_HIGH_CYC);
    localparam logic [BW-1:0] LAST_BIT = BW'(BITS_PER_PIXEL - 1);
    localparam logic [PX_COUNT_WIDTH-1:0] PX_LIMIT = PX_COUNT_WIDTH'(PX_NUM);

    rx_state_e                 r_state;
    logic [BITS_PER_PIXEL-1:0] r_shift;
    logic [BW-1:0]             r_bit_cnt;
    logic [PX_COUNT_WIDTH-1:0] r_idx;
    logic [BITS_PER_PIXEL-1:0] r_pixel_data;
    logic [PX_COUNT_WIDTH-1:0] r_pixel_idx;
    logic                      r_pixel_valid;
    logic                      r_frame_done;
    logic                      r_bit_err;
    logic                      r_overflow;

    logic                      w_rise;
    logic                      w_fall;
    logic                      w_gap_hit;
    logic [HW-1:0]             w_high_cnt;
    logic                      w_bit;
    logic                      w_bad_pulse;
    logic [BITS_PER_PIXEL-1:0] w_word;

    ws2812_pulse_meter #(
        .MAX_HIGH_CYC (MAX_HIGH_CYC),
        .GAP_CYC      (GAP_CYC)
    ) u_meter (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_din      (din),
        .o_rise     (w_rise),
        .o_fall     (w_fall),
        .o_high_cnt (w_high_cnt),
        .o_gap_hit  (w_gap_hit)
    );

    assign w_bit       = (w_high_cnt >= THR_H);
    assign w_bad_pulse = (w_high_cnt < MIN_H) || (w_high_cnt > MAX_H);
    assign w_word      = {r_shift[BITS_PER_PIXEL-2:0], w_bit};

    // Frame/bit state machine with registered strobes and sticky error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_SYNC_WAIT;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_idx         <= '0;
            r_pixel_data  <= '0;
            r_pixel_idx   <= '0;
            r_pixel_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_bit_err     <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            // Errors stay visible alongside the frame_done strobe, then clear
            if (r_frame_done) begin
                r_bit_err  <= 1'b0;
                r_overflow <= 1'b0;
            end
            case (r_state)
                ST_SYNC_WAIT: begin
                    if (w_gap_hit) begin
                        r_state   <= ST_IDLE;
                        r_idx     <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (w_fall) begin
                        if (w_bad_pulse) begin
                            r_bit_err <= 1'b1;
                            r_bit_cnt <= '0;
                            r_state   <= ST_ERR_SKIP;
                        end else begin
                            r_state <= ST_LOW;
                            if (r_bit_cnt == LAST_BIT) begin
                                r_bit_cnt <= '0;
                                if (r_idx == PX_LIMIT) begin
                                    r_overflow <= 1'b1;
                                end else begin
                                    r_pixel_valid <= 1'b1;
                                    r_pixel_data  <= w_word;
                                    r_pixel_idx   <= r_idx;
                                    r_idx         <= r_idx + PX_COUNT_WIDTH'(1);
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BW'(1);
                                r_shift   <= w_word;
                            end
                        end
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        r_state <= ST_HIGH;
                    end else if (w_gap_hit) begin
                        r_frame_done <= 1'b1;
                        r_idx        <= '0;
                        r_bit_cnt    <= '0;
                        if (r_bit_cnt != '0) begin
                            r_bit_err <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                ST_ERR_SKIP: begin
                    if (w_gap_hit) begin
                        r_frame_done <= 1'b1;
                        r_idx        <= '0;
                        r_bit_cnt    <= '0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_SYNC_WAIT;
                end
            endcase
        end
    end

    assign pixel_data  = r_pixel_data;
    assign pixel_idx   = r_pixel_idx;
    assign pixel_valid = r_pixel_valid;
    assign frame_done  = r_frame_done;
    assign bit_err     = r_bit_err;
    assign overflow    = r_overflow;

`ifdef WS2812_RX_STATS_EN
    logic [15:0] r_frame_count;

    // Completed-frame counter, wraps naturally at 2^16
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_count <= 16'd0;
        end else if (r_frame_done) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`else
    assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Self-checking bench for ws2812_rx_decoder using scaled pulse timings.
module tb_ws2812_rx_decoder;

    localparam int GAP = 200;
    localparam int PXN = 52;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    logic [23:0] pixel_data;
    logic [5:0]  pixel_idx;
    logic        pixel_valid;
    logic        frame_done;
    logic        bit_err;
    logic        overflow;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    ws2812_rx_decoder #(
        .PX_NUM         (PXN),
        .MIN_HIGH_CYC   (4),
        .BIT_THRESH_CYC (10),
        .MAX_HIGH_CYC   (20),
        .GAP_CYC        (GAP)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .din         (din),
        .pixel_data  (pixel_data),
        .pixel_idx   (pixel_idx),
        .pixel_valid (pixel_valid),
        .frame_done  (frame_done),
        .bit_err     (bit_err),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    typedef struct {
        int          npix;
        logic [23:0] d0;
        logic [23:0] d1;
        int          part_bits;
        int          glitch_px;
        int          glitch_bit;
        logic        exp_err;
        logic        exp_ovf;
    } frame_t;

    typedef struct {
        logic [23:0] data;
        logic [5:0]  idx;
    } exp_t;

    frame_t vec[6];
    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    int     fd_cnt = 0;
    logic   fd_err = 1'b0;
    logic   fd_ovf = 1'b0;
    logic   prev_fd = 1'b0;
    int     exp_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_fc(input int n);
`ifdef WS2812_RX_STATS_EN
        return 16'(n);
`else
        return 16'd0 & 16'(n);
`endif
    endfunction

    // Scoreboard and frame_done monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (pixel_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got data %0h idx %0d, expected none", pixel_data, pixel_idx);
                end else begin
                    e = sb.pop_front();
                    check("pixel_data", 32'(pixel_data), 32'(e.data));
                    check("pixel_idx", 32'(pixel_idx), 32'(e.idx));
                end
            end
            if (prev_fd) begin
                check("err_cleared", 32'(bit_err), 32'd0);
                check("ovf_cleared", 32'(overflow), 32'd0);
            end
            if (frame_done) begin
                fd_cnt++;
                fd_err = bit_err;
                fd_ovf = overflow;
            end
            prev_fd = frame_done;
        end else begin
            prev_fd = 1'b0;
        end
    end

    task automatic hold(input logic lvl, input int n);
        din = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            hold(1'b1, 14);
            hold(1'b0, 3);
        end else begin
            hold(1'b1, 6);
            hold(1'b0, 3);
        end
    endtask

    task automatic send_pixel(input logic [23:0] p);
        for (int i = 23; i >= 0; i--) send_bit(p[i]);
    endtask

    task automatic wait_frame(input string name);
        int start;
        start = fd_cnt;
        din = 1'b0;
        for (int k = 0; k < 2 * GAP && fd_cnt == start; k++) @(negedge clk);
        check({name, "_frame_done"}, 32'(fd_cnt - start), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [23:0] p;
        int          k;
        vec[0] = '{1,  24'hFF0055, 24'hFF0055, 0,  -1, 0, 1'b0, 1'b0};
        vec[1] = '{52, 24'h000000, 24'hFFFFFF, 0,  -1, 0, 1'b0, 1'b0};
        vec[2] = '{53, 24'h5A5A5A, 24'hA5A5A5, 0,  -1, 0, 1'b0, 1'b1};
        vec[3] = '{6,  24'h123456, 24'h654321, 0,  3,  7, 1'b1, 1'b0};
        vec[4] = '{0,  24'h000000, 24'h000000, 12, -1, 0, 1'b1, 1'b0};
        vec[5] = '{2,  24'hABCDEF, 24'h0F0F0F, 0,  -1, 0, 1'b0, 1'b0};

        rst_n = 1'b0;
        din   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(pixel_data), 32'd0);
        check("rst_idx", 32'(pixel_idx), 32'd0);
        check("rst_valid", 32'(pixel_valid), 32'd0);
        check("rst_err", 32'(bit_err), 32'd0);
        check("rst_fc", 32'(frame_count), 32'd0);
        rst_n = 1'b1;
        hold(1'b0, GAP + 20);
        check("sync_no_frame_done", 32'(fd_cnt), 32'd0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vec[v].npix; i++) begin
                p = (i % 2 == 0) ? vec[v].d0 : vec[v].d1;
                if (i < PXN && !(vec[v].glitch_px >= 0 && i >= vec[v].glitch_px))
                    sb.push_back('{p, 6'(i)});
                if (i == vec[v].glitch_px) begin
                    for (int b = 0; b < 24; b++) begin
                        if (b == vec[v].glitch_bit) begin
                            hold(1'b1, 2);
                            hold(1'b0, 3);
                        end else begin
                            send_bit(p[23-b]);
                        end
                    end
                end else begin
                    send_pixel(p);
                end
            end
            for (int b = 0; b < vec[v].part_bits; b++) send_bit(1'(b));
            wait_frame($sformatf("vec%0d", v));
            exp_frames++;
            check($sformatf("vec%0d_err", v), 32'(fd_err), 32'(vec[v].exp_err));
            check($sformatf("vec%0d_ovf", v), 32'(fd_ovf), 32'(vec[v].exp_ovf));
            check($sformatf("vec%0d_drained", v), 32'(sb.size()), 32'd0);
            check($sformatf("vec%0d_fc", v), 32'(frame_count), 32'(exp_fc(exp_frames)));
        end

        // Raw-fall to pixel_valid latency on the final bit
        p = 24'hC3C3C3;
        sb.push_back('{p, 6'd0});
        for (int i = 23; i >= 1; i--) send_bit(p[i]);
        hold(1'b1, 14);
        din = 1'b0;
        k = 0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (pixel_valid) begin
                k = j;
                break;
            end
        end
        check("latency", 32'(k), 32'd4);
        wait_frame("latency");
        exp_frames++;

        // Reset in the middle of pixel 5
        for (int i = 0; i < 5; i++) begin
            p = 24'h0F00F0 ^ 24'(i * 24'h010101);
            sb.push_back('{p, 6'(i)});
            send_pixel(p);
        end
        for (int b = 0; b < 12; b++) send_bit(1'(b));
        rst_n = 1'b0;
        din   = 1'b0;
        #1;
        check("mid_rst_data", 32'(pixel_data), 32'd0);
        check("mid_rst_idx", 32'(pixel_idx), 32'd0);
        check("mid_rst_valid", 32'(pixel_valid), 32'd0);
        check("mid_rst_fd", 32'(frame_done), 32'd0);
        check("mid_rst_err", 32'(bit_err), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_fc", 32'(frame_count), 32'd0);
        check("mid_rst_drained", 32'(sb.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_frames = 0;
        k = fd_cnt;
        send_pixel(24'hFFFFFF);
        hold(1'b0, GAP + 20);
        check("resync_no_frame_done", 32'(fd_cnt - k), 32'd0);
        sb.push_back('{24'h00FF00, 6'd0});
        send_pixel(24'h00FF00);
        wait_frame("resync");
        exp_frames++;
        check("resync_err", 32'(fd_err), 32'd0);
        check("resync_drained", 32'(sb.size()), 32'd0);
        check("resync_fc", 32'(frame_count), 32'(exp_fc(exp_frames)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
